// File: rtl/multi_lane_score_engine_if.sv
// Judgement/statistics bundle between the note judge and the score engine.
// Master drives game state and lane hits; slave returns game statistics.
interface multi_lane_score_engine_if #(
    parameter int LANES   = 4,
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
);
    logic [1:0]           game_state;
    logic [LANES-1:0]     hit_valid;
    logic [2*LANES-1:0]   hit_grade;
    logic [SCORE_W-1:0]   score;
    logic [COMBO_W-1:0]   combo;
    logic [COMBO_W-1:0]   max_combo;
    logic [4:0]           multiplier;
    logic                 score_sat;

    modport master (
        output game_state, hit_valid, hit_grade,
        input  score, combo, max_combo, multiplier, score_sat
    );

    modport slave (
        input  game_state, hit_valid, hit_grade,
        output score, combo, max_combo, multiplier, score_sat
    );
endinterface

// File: rtl/multi_lane_score_engine.sv
// Two-stage multi-lane score/combo engine for the rhythm-game datapath.
// Stage 1 sums lane points, stage 2 applies multiplier, combo and clamps.
module multi_lane_score_engine #(
    parameter int LANES       = 4,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int BAND        = 16,
    parameter int MAX_MULT    = 17,
    parameter int PTS_GOOD    = 1,
    parameter int PTS_GREAT   = 2,
    parameter int PTS_PERFECT = 4
) (
    input  logic clk,
    input  logic reset,
    multi_lane_score_engine_if.slave bus
);
    localparam int PW  = $clog2(LANES * PTS_PERFECT + 1);
    localparam int CW  = $clog2(LANES + 1);
    localparam int AW  = PW + 5;
    localparam int SW  = SCORE_W + 1;
    localparam int BSH = $clog2(BAND);
    localparam logic [1:0] GS_PLAY = 2'd2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    logic [1:0]         gs_q;
    logic               s1_valid_q;
    logic [PW-1:0]      s1_pts_q;
    logic [CW-1:0]      s1_cnt_q;
    logic               s1_miss_q;
    logic [SCORE_W-1:0] score_q;
    logic [COMBO_W-1:0] combo_q;
    logic [COMBO_W-1:0] max_combo_q;
    logic               sat_q;

    logic               play;
    logic               entry;
    logic [PW-1:0]      pts_d;
    logic [CW-1:0]      cnt_d;
    logic               miss_d;
    logic               valid_d;
    logic [1:0]         grade;
    logic [COMBO_W:0]   mult_raw;
    logic [4:0]         mult;
    logic [AW-1:0]      add;
    logic [SW-1:0]      score_sum;
    logic [SCORE_W-1:0] score_d;
    logic               sat_hit;
    logic [COMBO_W:0]   combo_sum;
    logic [COMBO_W-1:0] combo_d;
    logic [COMBO_W-1:0] max_combo_d;

    assign play  = (bus.game_state == GS_PLAY);
    assign entry = play && (gs_q != GS_PLAY);

    // Stage-1 combinational lane reduction over accepted lanes.
    always_comb begin
        pts_d   = '0;
        cnt_d   = '0;
        miss_d  = 1'b0;
        valid_d = 1'b0;
        grade   = 2'b00;
        for (int i = 0; i < LANES; i++) begin
            grade = bus.hit_grade[2*i +: 2];
            if (play && bus.hit_valid[i]) begin
                valid_d = 1'b1;
                case (grade)
                    2'b01:   pts_d = pts_d + PW'(PTS_GOOD);
                    2'b10:   pts_d = pts_d + PW'(PTS_GREAT);
                    2'b11:   pts_d = pts_d + PW'(PTS_PERFECT);
                    default: miss_d = 1'b1;
                endcase
                if (grade != 2'b00) begin
                    cnt_d = cnt_d + CW'(1);
                end
            end
        end
    end

    // Multiplier decoded from the combo register, clamped to the ceiling.
    always_comb begin
        mult_raw = {1'b0, combo_q >> BSH} + (COMBO_W+1)'(1);
        if (mult_raw > (COMBO_W+1)'(MAX_MULT)) begin
            mult = 5'(MAX_MULT);
        end else begin
            mult = 5'(mult_raw);
        end
    end

    // Stage-2 next-state: saturating score, combo and max combo.
    always_comb begin
        add       = AW'(s1_pts_q) * AW'(mult);
        score_sum = {1'b0, score_q} + SW'(add);
        sat_hit   = score_sum[SW-1];
        score_d   = sat_hit ? SCORE_MAX : score_sum[SCORE_W-1:0];
        combo_sum = {1'b0, combo_q} + (COMBO_W+1)'(s1_cnt_q);
        if (s1_miss_q) begin
            combo_d = '0;
        end else if (combo_sum[COMBO_W]) begin
            combo_d = COMBO_MAX;
        end else begin
            combo_d = combo_sum[COMBO_W-1:0];
        end
        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    // Game-state history and stage-1 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gs_q       <= 2'd0;
            s1_valid_q <= 1'b0;
            s1_pts_q   <= '0;
            s1_cnt_q   <= '0;
            s1_miss_q  <= 1'b0;
        end else begin
            gs_q       <= bus.game_state;
            s1_valid_q <= valid_d;
            s1_pts_q   <= pts_d;
            s1_cnt_q   <= cnt_d;
            s1_miss_q  <= miss_d;
        end
    end

    // Statistics registers: cleared on game entry, updated by stage 2.
    always_ff @(posedge clk) begin
        if (reset || entry) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            sat_q       <= 1'b0;
        end else if (s1_valid_q) begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            sat_q       <= sat_q | sat_hit;
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.multiplier = mult;
    assign bus.score_sat  = sat_q;
endmodule

// File: tb/tb_multi_lane_score_engine.sv
// Directed bench for multi_lane_score_engine with a reference-model
// scoreboard plus hand-derived constant checks at key points.
module tb_multi_lane_score_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_lane_score_engine_if #(.LANES(4), .SCORE_W(16), .COMBO_W(8)) ifc ();

    multi_lane_score_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct {
        int score;
        int combo;
        int maxc;
        int mult;
        int sat;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int m_score, m_combo, m_max, m_sat;
    logic [1:0] m_gs;
    logic h1, h2;

    function automatic int m_mult();
        int m;
        m = 1 + m_combo / 16;
        return (m > 17) ? 17 : m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] gs,
                       input logic [3:0] v, input logic [7:0] g);
        logic acc;
        int pts, cnt, miss, add;
        exp_t e;
        acc = 1'b0;
        reset = r;
        ifc.game_state = gs;
        ifc.hit_valid = v;
        ifc.hit_grade = g;
        if (r) begin
            m_score = 0; m_combo = 0; m_max = 0; m_sat = 0;
            m_gs = 2'd0;
            q.delete();
        end else begin
            if (gs == 2'd2 && m_gs != 2'd2) begin
                m_score = 0; m_combo = 0; m_max = 0; m_sat = 0;
            end
            pts = 0; cnt = 0; miss = 0;
            if (gs == 2'd2) begin
                for (int i = 0; i < 4; i++) begin
                    if (v[i]) begin
                        acc = 1'b1;
                        case (g[2*i +: 2])
                            2'b01: begin pts += 1; cnt++; end
                            2'b10: begin pts += 2; cnt++; end
                            2'b11: begin pts += 4; cnt++; end
                            default: miss = 1;
                        endcase
                    end
                end
            end
            if (acc) begin
                add = pts * m_mult();
                m_score += add;
                if (m_score > 65535) begin
                    m_score = 65535;
                    m_sat = 1;
                end
                m_combo = miss ? 0 : m_combo + cnt;
                if (m_combo > 255) m_combo = 255;
                if (m_combo > m_max) m_max = m_combo;
                e.score = m_score; e.combo = m_combo; e.maxc = m_max;
                e.mult = m_mult(); e.sat = m_sat;
                q.push_back(e);
            end
            m_gs = gs;
        end
        @(posedge clk);
        if (r) begin
            h1 = 1'b0; h2 = 1'b0;
        end else begin
            h2 = h1; h1 = acc;
        end
        #1;
        if (h2) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_score", 32'(ifc.score), 32'(e.score));
                chk("sb_combo", 32'(ifc.combo), 32'(e.combo));
                chk("sb_max", 32'(ifc.max_combo), 32'(e.maxc));
                chk("sb_mult", 32'(ifc.multiplier), 32'(e.mult));
                chk("sb_sat", 32'(ifc.score_sat), 32'(e.sat));
            end
        end
    endtask

    task automatic idle(input logic [1:0] gs, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, gs, 4'h0, 8'h00);
    endtask

    initial begin
        h1 = 1'b0; h2 = 1'b0;
        m_gs = 2'd0;
        m_score = 0; m_combo = 0; m_max = 0; m_sat = 0;
        ifc.game_state = 2'd0;
        ifc.hit_valid = '0;
        ifc.hit_grade = '0;

        cyc(1'b1, 2'd0, 4'h0, 8'h00);
        cyc(1'b1, 2'd0, 4'h0, 8'h00);
        chk("rst_score", 32'(ifc.score), 0);
        chk("rst_combo", 32'(ifc.combo), 0);
        chk("rst_max", 32'(ifc.max_combo), 0);
        chk("rst_mult", 32'(ifc.multiplier), 1);
        chk("rst_sat", 32'(ifc.score_sat), 0);

        cyc(1'b0, 2'd2, 4'h1, 8'h03);
        chk("lat_early_score", 32'(ifc.score), 0);
        chk("lat_early_combo", 32'(ifc.combo), 0);
        idle(2'd2, 1);
        chk("lat_score", 32'(ifc.score), 4);
        chk("lat_combo", 32'(ifc.combo), 1);
        chk("lat_mult", 32'(ifc.multiplier), 1);

        idle(2'd3, 3);
        chk("over_hold", 32'(ifc.score), 4);
        idle(2'd2, 1);
        chk("reentry_score", 32'(ifc.score), 0);
        chk("reentry_combo", 32'(ifc.combo), 0);
        chk("reentry_max", 32'(ifc.max_combo), 0);

        for (int i = 0; i < 16; i++) cyc(1'b0, 2'd2, 4'h1, 8'h01);
        idle(2'd2, 2);
        chk("step_combo", 32'(ifc.combo), 16);
        chk("step_score", 32'(ifc.score), 16);
        chk("step_mult", 32'(ifc.multiplier), 2);
        cyc(1'b0, 2'd2, 4'h1, 8'h01);
        idle(2'd2, 2);
        chk("step17_score", 32'(ifc.score), 18);
        chk("step17_combo", 32'(ifc.combo), 17);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd2, 4'h1, 8'h01);
        idle(2'd2, 2);
        chk("c20_combo", 32'(ifc.combo), 20);
        chk("c20_score", 32'(ifc.score), 24);

        cyc(1'b0, 2'd2, 4'h3, 8'h03);
        idle(2'd2, 2);
        chk("miss_score", 32'(ifc.score), 32);
        chk("miss_combo", 32'(ifc.combo), 0);
        chk("miss_max", 32'(ifc.max_combo), 20);
        chk("miss_mult", 32'(ifc.multiplier), 1);

        cyc(1'b0, 2'd2, 4'hF, 8'hFF);
        idle(2'd2, 2);
        chk("multi_score", 32'(ifc.score), 48);
        chk("multi_combo", 32'(ifc.combo), 4);

        for (int i = 0; i < 70; i++) cyc(1'b0, 2'd2, 4'hF, 8'h55);
        idle(2'd2, 2);
        chk("combo_sat", 32'(ifc.combo), 255);
        chk("max_sat", 32'(ifc.max_combo), 255);
        chk("mult_top", 32'(ifc.multiplier), 16);
        chk("sat_clear", 32'(ifc.score_sat), 0);

        for (int i = 0; i < 300; i++) cyc(1'b0, 2'd2, 4'hF, 8'hFF);
        idle(2'd2, 2);
        chk("score_clamp", 32'(ifc.score), 65535);
        chk("score_sat", 32'(ifc.score_sat), 1);

        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd1, 4'hF, 8'hFF);
        idle(2'd1, 2);
        chk("sel_ignore_score", 32'(ifc.score), 65535);
        chk("sel_ignore_combo", 32'(ifc.combo), 255);
        idle(2'd2, 1);
        chk("clr_score", 32'(ifc.score), 0);
        chk("clr_combo", 32'(ifc.combo), 0);
        chk("clr_max", 32'(ifc.max_combo), 0);
        chk("clr_sat", 32'(ifc.score_sat), 0);
        chk("clr_mult", 32'(ifc.multiplier), 1);

        cyc(1'b0, 2'd2, 4'h1, 8'h02);
        idle(2'd3, 4);
        chk("flight_score", 32'(ifc.score), 2);
        chk("flight_combo", 32'(ifc.combo), 1);

        cyc(1'b0, 2'd2, 4'hF, 8'hFF);
        cyc(1'b1, 2'd2, 4'h0, 8'h00);
        chk("mid_rst_score", 32'(ifc.score), 0);
        chk("mid_rst_combo", 32'(ifc.combo), 0);
        chk("mid_rst_max", 32'(ifc.max_combo), 0);
        chk("mid_rst_mult", 32'(ifc.multiplier), 1);
        idle(2'd0, 2);
        chk("mid_rst_drop", 32'(ifc.score), 0);
        chk("sb_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
